// File: rtl/ibex_fetch_pkg.sv
// rtl/ibex_fetch_pkg.sv - shared types and constants for the fetch request controller
package ibex_fetch_pkg;

    localparam logic [31:0] FETCH_WORD_INCR = 32'd4;

    typedef struct packed {
        logic valid;
        logic discard;
    } fetch_slot_t;

endpackage

// File: rtl/ibex_fetch_outstanding_tracker.sv
// rtl/ibex_fetch_outstanding_tracker.sv - in-order outstanding-response slots (slot 0 oldest)
module ibex_fetch_outstanding_tracker
    import ibex_fetch_pkg::*;
#(
    parameter int NUM_REQS = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_push,
    input  logic                          i_push_discard,
    input  logic                          i_pop,
    input  logic                          i_discard_all,
    output logic [$clog2(NUM_REQS+1)-1:0] o_count,
    output fetch_slot_t                   o_slot0,
    output logic                          o_any_valid,
    output logic                          o_full
);

    localparam int CW = $clog2(NUM_REQS + 1);

    fetch_slot_t [NUM_REQS-1:0] r_slots;
    fetch_slot_t [NUM_REQS-1:0] w_shift;
    fetch_slot_t [NUM_REQS-1:0] w_next;
    logic                       w_placed;

    // Pop first, then mark survivors, then place the new grant in the lowest free slot.
    always_comb begin
        w_shift = r_slots;
        if (i_pop && r_slots[0].valid) begin
            for (int i = 0; i < NUM_REQS - 1; i++) begin
                w_shift[i] = r_slots[i+1];
            end
            w_shift[NUM_REQS-1] = '0;
        end
        if (i_discard_all) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                w_shift[i].discard = w_shift[i].discard | w_shift[i].valid;
            end
        end
        w_next   = w_shift;
        w_placed = 1'b0;
        if (i_push) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!w_placed && !w_shift[i].valid) begin
                    w_next[i].valid   = 1'b1;
                    w_next[i].discard = i_push_discard;
                    w_placed          = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slots <= '0;
        end else begin
            r_slots <= w_next;
        end
    end

    always_comb begin
        o_count     = '0;
        o_any_valid = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            o_count     = o_count + CW'(r_slots[i].valid);
            o_any_valid = o_any_valid | r_slots[i].valid;
        end
    end

    assign o_slot0 = r_slots[0];
    assign o_full  = r_slots[NUM_REQS-1].valid;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// rtl/ibex_fetch_req_ctrl.sv - instruction-bus request issue, response filtering and FIFO push
module ibex_fetch_req_ctrl
    import ibex_fetch_pkg::*;
#(
    parameter int NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    localparam int CW = $clog2(NUM_REQS + 1);
    localparam int OW = CW + 1;

    logic        r_started;
    logic        r_pend;
    logic        r_pend_discard;
    logic [31:0] r_pend_addr;
    logic [31:0] r_fetch_addr;

    logic [CW-1:0] w_count;
    fetch_slot_t   w_slot0;
    logic          w_any_valid;
    logic          w_full;
    logic [OW-1:0] w_busy_cnt;
    logic [OW-1:0] w_occupancy;
    logic [31:0]   w_target;
    logic [31:0]   w_new_addr;
    logic          w_new_req_ok;
    logic          w_grant;
    logic          w_pop;
    logic          w_push_discard;

    always_comb begin
        w_busy_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            w_busy_cnt = w_busy_cnt + OW'(fifo_busy_i[i]);
        end
    end

    assign w_occupancy  = OW'(w_count) + w_busy_cnt;
    assign w_target     = {addr_i[31:2], 2'b00};
    assign w_new_req_ok = req_i & r_started & (w_occupancy < OW'(NUM_REQS));
    // A fresh request in a branch cycle goes straight to the new target.
    assign w_new_addr   = branch_i ? w_target : {r_fetch_addr[31:2], 2'b00};

    assign instr_req_o  = r_pend | w_new_req_ok;
    assign instr_addr_o = r_pend ? r_pend_addr : w_new_addr;
    assign w_grant      = instr_req_o & instr_gnt_i;

    // Only a held request can be stale; a fresh one always reflects the latest target.
    assign w_push_discard = r_pend & (r_pend_discard | branch_i);
    assign w_pop          = instr_rvalid_i & w_slot0.valid;

    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = w_pop & ~w_slot0.discard & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign busy_o       = r_pend | w_any_valid;

    ibex_fetch_outstanding_tracker #(
        .NUM_REQS(NUM_REQS)
    ) u_tracker (
        .i_clk         (clk_i),
        .i_rst         (rst_i),
        .i_push        (w_grant),
        .i_push_discard(w_push_discard),
        .i_pop         (instr_rvalid_i),
        .i_discard_all (branch_i),
        .o_count       (w_count),
        .o_slot0       (w_slot0),
        .o_any_valid   (w_any_valid),
        .o_full        (w_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_started      <= 1'b0;
            r_pend         <= 1'b0;
            r_pend_discard <= 1'b0;
            r_pend_addr    <= '0;
            r_fetch_addr   <= '0;
        end else begin
            if (branch_i) begin
                r_started <= 1'b1;
            end
            // The fetch pointer advances as soon as a fresh address is on the bus,
            // so a held request never repeats once it is finally granted.
            if (!r_pend && w_new_req_ok) begin
                r_fetch_addr <= w_new_addr + FETCH_WORD_INCR;
            end else if (branch_i) begin
                r_fetch_addr <= w_target;
            end
            if (r_pend) begin
                if (instr_gnt_i) begin
                    r_pend <= 1'b0;
                end else if (branch_i) begin
                    r_pend_discard <= 1'b1;
                end
            end else if (w_new_req_ok && !instr_gnt_i) begin
                r_pend         <= 1'b1;
                r_pend_addr    <= w_new_addr;
                r_pend_discard <= 1'b0;
            end
        end
    end

    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));

    a_no_grant_full: assert property (@(posedge clk_i) disable iff (rst_i)
        (w_grant && w_full) |-> instr_rvalid_i);

    a_rvalid_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> w_slot0.valid);

    a_no_push_full_fifo: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_valid_o |-> !(&fifo_busy_i));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// tb/tb_ibex_fetch_req_ctrl.sv - randomized self-checking bench with an address-level reference model
module tb_ibex_fetch_req_ctrl;

    localparam int N = 2;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         req_i = 1'b0;
    logic         branch_i = 1'b0;
    logic [31:0]  addr_i = '0;
    logic         busy_o;
    logic [N-1:0] fifo_busy_i = '0;
    logic         fifo_clear_o;
    logic         fifo_valid_o;
    logic [31:0]  fifo_addr_o;
    logic [31:0]  fifo_rdata_o;
    logic         fifo_err_o;
    logic         instr_req_o;
    logic         instr_gnt_i = 1'b0;
    logic [31:0]  instr_addr_o;
    logic         instr_rvalid_i = 1'b0;
    logic [31:0]  instr_rdata_i = '0;
    logic         instr_err_i = 1'b0;

    ibex_fetch_req_ctrl #(.NUM_REQS(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .branch_i      (branch_i),
        .addr_i        (addr_i),
        .busy_o        (busy_o),
        .fifo_busy_i   (fifo_busy_i),
        .fifo_clear_o  (fifo_clear_o),
        .fifo_valid_o  (fifo_valid_o),
        .fifo_addr_o   (fifo_addr_o),
        .fifo_rdata_o  (fifo_rdata_o),
        .fifo_err_o    (fifo_err_o),
        .instr_req_o   (instr_req_o),
        .instr_gnt_i   (instr_gnt_i),
        .instr_addr_o  (instr_addr_o),
        .instr_rvalid_i(instr_rvalid_i),
        .instr_rdata_i (instr_rdata_i),
        .instr_err_i   (instr_err_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return ^a[6:2];
    endfunction

    // Reference: in-flight fetches as a queue of addresses, each flagged stale once a branch passes it.
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } out_t;

    out_t        m_out[$];
    bit          m_started;
    bit          m_pend;
    bit          m_pend_stale;
    logic [31:0] m_pend_addr;
    logic [31:0] m_next;

    logic [31:0] obs_gnt[$];
    logic [31:0] obs_push[$];
    int          obs_clear = 0;

    task automatic m_reset();
        m_out.delete();
        m_started    = 1'b0;
        m_pend       = 1'b0;
        m_pend_stale = 1'b0;
        m_pend_addr  = '0;
        m_next       = '0;
    endtask

    task automatic clear_logs();
        obs_gnt.delete();
        obs_push.delete();
        obs_clear = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i          = 1'b1;
        req_i          = 1'b0;
        branch_i       = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        fifo_busy_i    = '0;
        @(negedge clk);
        #1;
        chk("rst_req", 32'(instr_req_o), 32'd0);
        chk("rst_fifo_valid", 32'(fifo_valid_o), 32'd0);
        chk("rst_clear", 32'(fifo_clear_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        m_reset();
    endtask

    task automatic cyc(input bit req, input bit br, input logic [31:0] ba,
                       input bit gnt, input bit rv, input logic [N-1:0] busy);
        bit          rv_eff, new_ok, exp_req, exp_push, grant, was_pend;
        logic [31:0] tgt, exp_addr;
        out_t        e;
        @(negedge clk);
        rv_eff         = rv && (m_out.size() > 0);
        rst_i          = 1'b0;
        req_i          = req;
        branch_i       = br;
        addr_i         = ba;
        instr_gnt_i    = gnt;
        fifo_busy_i    = busy;
        instr_rvalid_i = rv_eff;
        instr_rdata_i  = rv_eff ? mem_data(m_out[0].addr) : $urandom;
        instr_err_i    = rv_eff ? mem_err(m_out[0].addr) : 1'b0;
        #1;
        tgt      = {ba[31:2], 2'b00};
        new_ok   = req && m_started && (m_out.size() + $countones(busy) < N);
        exp_req  = m_pend || new_ok;
        exp_addr = m_pend ? m_pend_addr : (br ? tgt : m_next);
        exp_push = rv_eff ? (!m_out[0].stale && !br) : 1'b0;

        chk("instr_req", 32'(instr_req_o), 32'(exp_req));
        if (exp_req) chk("instr_addr", instr_addr_o, exp_addr);
        chk("fifo_valid", 32'(fifo_valid_o), 32'(exp_push));
        if (exp_push) begin
            chk("fifo_rdata", fifo_rdata_o, mem_data(m_out[0].addr));
            chk("fifo_err", 32'(fifo_err_o), 32'(mem_err(m_out[0].addr)));
        end
        chk("fifo_clear", 32'(fifo_clear_o), 32'(br));
        chk("fifo_addr", fifo_addr_o, ba);
        chk("busy", 32'(busy_o), 32'(m_pend || m_out.size() > 0));

        if (instr_req_o && gnt) obs_gnt.push_back(instr_addr_o);
        if (fifo_valid_o) obs_push.push_back(fifo_rdata_o);
        if (fifo_clear_o) obs_clear++;

        grant    = exp_req && gnt;
        was_pend = m_pend;
        if (rv_eff) void'(m_out.pop_front());
        if (br) begin
            for (int i = 0; i < m_out.size(); i++) m_out[i].stale = 1'b1;
        end
        if (grant) begin
            e.addr  = exp_addr;
            e.stale = was_pend && (m_pend_stale || br);
            m_out.push_back(e);
        end
        if (was_pend) begin
            if (gnt) m_pend = 1'b0;
            else if (br) m_pend_stale = 1'b1;
        end else if (new_ok && !gnt) begin
            m_pend       = 1'b1;
            m_pend_addr  = exp_addr;
            m_pend_stale = 1'b0;
        end
        if (!was_pend && new_ok) m_next = exp_addr + 32'd4;
        else if (br) m_next = tgt;
        if (br) m_started = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (m_pend || m_out.size() > 0); i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00);
        end
    endtask

    initial begin
        logic [N-1:0] b;
        m_reset();
        do_reset();

        // Boot from 0x80 with grant every cycle and one-cycle response latency.
        clear_logs();
        cyc(1'b1, 1'b1, 32'h80, 1'b1, 1'b0, 2'b00);
        repeat (4) cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00);
        chk("boot_gnt0", obs_gnt[0], 32'h80);
        chk("boot_gnt1", obs_gnt[1], 32'h84);
        chk("boot_gnt2", obs_gnt[2], 32'h88);
        chk("boot_push0", obs_push[0], mem_data(32'h80));
        chk("boot_push2", obs_push[2], mem_data(32'h88));
        chk("boot_clear_pulses", 32'(obs_clear), 32'd1);
        drain();

        // Grant withheld on 0x100 while a branch to 0x200 arrives.
        clear_logs();
        cyc(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 1'b1, 32'h202, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'b00);
        chk("held_gnt0", obs_gnt[0], 32'h100);
        chk("held_gnt1", obs_gnt[1], 32'h200);
        chk("held_first_push", obs_push[0], mem_data(32'h200));
        drain();

        // Two outstanding, then a branch to 0x300 before either response.
        clear_logs();
        cyc(1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 2'b00);
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 2'b00);
        chk("br2_gnt1", obs_gnt[1], 32'h44);
        chk("br2_gnt2", obs_gnt[2], 32'h300);
        chk("br2_first_push", obs_push[0], mem_data(32'h300));
        drain();

        // FIFO occupancy throttles new requests.
        clear_logs();
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b11);
        chk("fifo_full_no_gnt", 32'(obs_gnt.size()), 32'd0);
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b01);
        chk("fifo_half_one_gnt", 32'(obs_gnt.size()), 32'd1);
        drain();

        // Reset with two requests in flight; nothing issues until the next branch.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        do_reset();
        clear_logs();
        repeat (3) cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 2'b00);
        chk("post_rst_no_gnt", 32'(obs_gnt.size()), 32'd0);

        // Randomized traffic, including wrap near the top of the address space.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ba;
            if ($urandom_range(0, 499) == 0) do_reset();
            do b = N'($urandom_range(0, 3));
            while ($countones(b) + m_out.size() > N);
            ba = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hE))
                                             : ($urandom & 32'hFFFF_FFFE);
            cyc($urandom_range(0, 9) < 8, $urandom_range(0, 15) == 0, ba,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibex_fetch_req_ctrl.md
Name: ibex_fetch_req_ctrl

Overview:
- Request-side companion of the fetch FIFO. It issues word-aligned instruction-bus requests using the req/gnt/rvalid protocol.
- It tracks up to NUM_REQS outstanding responses and discards responses invalidated by branches.
- It pushes surviving responses into the fetch FIFO and drives the FIFO's clear and branch-address inputs.
- It sits between the IF-stage control and the fetch FIFO / instruction bus.

Parameters:
- NUM_REQS, 2: maximum outstanding bus requests. Must equal the fetch FIFO NUM_REQS.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  fetching enabled
- branch_i  in  1  redirect fetch to addr_i this cycle
- addr_i  in  32  branch target (halfword aligned)
- busy_o  out  1  any request pending or outstanding
- fifo_busy_i  in  NUM_REQS  FIFO upper-entry occupancy
- fifo_clear_o  out  1  FIFO clear
- fifo_valid_o  out  1  push response into FIFO
- fifo_addr_o  out  32  FIFO in_addr (branch target)
- fifo_rdata_o  out  32  pushed data
- fifo_err_o  out  1  pushed error
- instr_req_o  out  1  bus request
- instr_gnt_i  in  1  bus grant
- instr_addr_o  out  32  bus address, bits [1:0] = 0
- instr_rvalid_i  in  1  response valid
- instr_rdata_i  in  32  response data
- instr_err_i  in  1  response error

Behaviour:
- Interface: one clock, clk_i; reset is synchronous and active-high, rst_i. All state is sampled on posedge clk_i with rst_i=1.
- Reset state: all outstanding slots empty; no pending request; fetch_addr_q=0; started_q=0.
- Outputs during/after reset: instr_req_o=0, fifo_valid_o=0, fifo_clear_o=0, busy_o=0. No request is issued until the first branch_i (this carries the boot address).
- Combinational pass-through: fifo_clear_o=branch_i; fifo_addr_o=addr_i. branch_i sets started_q.
- Outstanding tracker: NUM_REQS slots, each {valid, discard}, kept in order with slot 0 oldest.
  - Grant (instr_req_o & instr_gnt_i) writes the lowest free slot.
  - rvalid pops slot 0 and shifts the rest down.
  - Grant and rvalid in the same cycle: pop first, then write the lowest free slot of the shifted state.
- Capacity rule: new_req_ok = req_i & started_q & (outstanding_count + popcount(fifo_busy_i) < NUM_REQS).
- Request issue: instr_req_o = pend_q | new_req_ok.
  - instr_addr_o = pend_q ? pend_addr_q : {fetch_addr_q[31:2],2'b00}.
  - If a request is not granted, pend_q=1. Address is held stable until gnt, regardless of req_i or branch_i.
- Address increment: on grant of a non-pending request, fetch_addr_q += 4. Wrap-around modulo 2^32.
- Branch handling (branch_i=1):
  - All valid outstanding slots get discard=1.
  - fetch_addr_q <= {addr_i[31:2],2'b00}.
  - A pending ungranted request is kept and granted normally, with its slot marked discard. The new target is issued the cycle after that grant.
  - A request granted in the branch cycle is also marked discard, unless it is the new-target request itself. That happens only when pend_q=0, in which case instr_addr_o is the new target combinationally.
- Response handling: fifo_valid_o = instr_rvalid_i & slot0.valid & ~slot0.discard & ~branch_i. fifo_rdata_o=instr_rdata_i; fifo_err_o=instr_err_i. A response arriving with branch_i=1 is dropped.
- rvalid with no valid outstanding slot: illegal (assertion); the tracker state is left unchanged.
- busy_o = pend_q | any slot valid.
- Assertions:
  - instr_addr_o stable while instr_req_o & ~instr_gnt_i.
  - No grant when all slots valid.
  - fifo_valid_o never asserted when fifo_busy_i is all ones.

Decomposition:
- ibex_fetch_pkg holds:
  - the outstanding-slot struct {valid, discard};
  - the constant FETCH_WORD_INCR=4.
- One sub-module, ibex_fetch_outstanding_tracker. It owns the NUM_REQS slot shift register with push/pop/mark-all-discard, and outputs count and slot 0.

Test Plan:
- Reset then branch_i=1, addr_i=0x80, req_i=1, gnt every cycle, rvalid 1 cycle later:
  - expect requests to 0x80, 0x84, 0x88;
  - fifo_clear_o pulses once;
  - fifo_valid_o with data in order.
- gnt withheld 3 cycles on 0x100 while branch_i pulses to 0x200:
  - instr_addr_o stays 0x100 until gnt;
  - the 0x100 response is dropped (fifo_valid_o=0);
  - the next request is 0x200.
- Two outstanding (0x40, 0x44), then branch to 0x300 before both rvalids:
  - both responses dropped;
  - first pushed data comes from 0x300.
- fifo_busy_i=2'b11 with req_i=1: instr_req_o=0. Clearing to 2'b01 with 0 outstanding permits exactly 1 request.
- rvalid and gnt in the same cycle with NUM_REQS slots full: count stays 2 and no overflow assertion fires.
- Reset asserted mid-flight with 2 outstanding: next cycle instr_req_o=0 and busy_o=0, and no request is made until branch_i.
